// File: rtl/arr_port_arbiter.sv
// arr_port_arbiter: shares one single-port, 1-cycle-read array memory between the
// host control port (requester 0) and the kernel FSM (requester 1). Round-robin
// between the two, with an exclusive host lock, out-of-range blocking and read-data
// routing back to whichever requester issued the read.
module arr_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_lock,
  // host port
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic              h_err,
  // kernel port
  input  logic              k_req,
  input  logic              k_we,
  input  logic [ADDR_W-1:0] k_addr,
  input  logic [DATA_W-1:0] k_wdata,
  output logic              k_gnt,
  output logic              k_rvalid,
  output logic [DATA_W-1:0] k_rdata,
  output logic              k_err,
  // memory side
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // One extra bit so DEPTH == 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] DEPTH_W = DEPTH[ADDR_W:0];

  typedef enum logic {ARB, LOCKED} state_t;

  state_t              state_reg;
  logic                last_k_reg;     // 1 = kernel was granted last (host wins next tie)
  logic [ADDR_W-1:0]   mem_addr_reg;   // address held on the memory bus when idle
  logic                tag_valid_reg;  // a read was granted last cycle
  logic                tag_owner_reg;  // 0 = host, 1 = kernel
  logic                tag_oob_reg;    // that read was out of range
  logic [DATA_W-1:0]   h_rdata_reg;
  logic [DATA_W-1:0]   k_rdata_reg;

  logic                lock_eff;
  logic                any_gnt;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_oob;
  logic [DATA_W-1:0]   rd_data;

  // The kernel stays stalled for the cycle in which host_lock drops, because the
  // FSM only returns to ARB on the following edge.
  assign lock_eff = host_lock || (state_reg == LOCKED);

  // Same-cycle grant decision; nothing is granted while reset is asserted.
  always_comb begin
    h_gnt = 1'b0;
    k_gnt = 1'b0;
    if (!rst) begin
      if (lock_eff) begin
        h_gnt = h_req;
      end else if (h_req && k_req) begin
        h_gnt = last_k_reg;
        k_gnt = !last_k_reg;
      end else begin
        h_gnt = h_req;
        k_gnt = k_req;
      end
    end
  end

  assign any_gnt   = h_gnt || k_gnt;
  assign sel_we    = k_gnt ? k_we    : h_we;
  assign sel_addr  = k_gnt ? k_addr  : h_addr;
  assign sel_wdata = k_gnt ? k_wdata : h_wdata;
  assign sel_oob   = any_gnt && ({1'b0, sel_addr} >= DEPTH_W);

  // Out-of-range addresses never reach the memory bus; the bus keeps its last address.
  assign mem_we    = any_gnt && sel_we && !sel_oob;
  assign mem_addr  = (any_gnt && !sel_oob) ? sel_addr : mem_addr_reg;
  assign mem_wdata = sel_wdata;

  assign h_err = h_gnt && sel_oob;
  assign k_err = k_gnt && sel_oob;

  // Read return is steered by the tag captured at grant time.
  assign rd_data  = tag_oob_reg ? '0 : mem_rdata;
  assign h_rvalid = !rst && tag_valid_reg && !tag_owner_reg;
  assign k_rvalid = !rst && tag_valid_reg &&  tag_owner_reg;
  assign h_rdata  = h_rvalid ? rd_data : h_rdata_reg;
  assign k_rdata  = k_rvalid ? rd_data : k_rdata_reg;

  // Lock FSM: ARB while host_lock is low, LOCKED while it is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ARB;
    end else begin
      case (state_reg)
        ARB:     if (host_lock)  state_reg <= LOCKED;
        LOCKED:  if (!host_lock) state_reg <= ARB;
        default: state_reg <= ARB;
      endcase
    end
  end

  // Round-robin pointer; only grants made outside the lock move it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_k_reg <= 1'b1;
    end else if (any_gnt && !lock_eff) begin
      last_k_reg <= k_gnt;
    end
  end

  // In-flight read tag and held memory address.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid_reg <= 1'b0;
      tag_owner_reg <= 1'b0;
      tag_oob_reg   <= 1'b0;
      mem_addr_reg  <= '0;
    end else begin
      tag_valid_reg <= any_gnt && !sel_we;
      tag_owner_reg <= k_gnt;
      tag_oob_reg   <= sel_oob;
      mem_addr_reg  <= mem_addr;
    end
  end

  // Read data holding registers, so rdata stays put while rvalid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_rdata_reg <= '0;
      k_rdata_reg <= '0;
    end else begin
      if (h_rvalid) h_rdata_reg <= rd_data;
      if (k_rvalid) k_rdata_reg <= rd_data;
    end
  end

endmodule

// File: tb/tb_arr_port_arbiter.sv
// Bench for arr_port_arbiter: a simple array memory on the memory side, directed
// scenarios followed by random traffic, all checked against a reference model
// built from the arbitration / range / latency rules.
module tb_arr_port_arbiter;

  logic        clk = 1'b0;
  logic        rst, host_lock;
  logic        h_req, h_we, k_req, k_we;
  logic [9:0]  h_addr, k_addr;
  logic [63:0] h_wdata, k_wdata;
  logic        h_gnt, h_rvalid, h_err, k_gnt, k_rvalid, k_err;
  logic [63:0] h_rdata, k_rdata;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [63:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arr_port_arbiter dut (
    .clk(clk), .rst(rst), .host_lock(host_lock),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata), .h_err(h_err),
    .k_req(k_req), .k_we(k_we), .k_addr(k_addr), .k_wdata(k_wdata),
    .k_gnt(k_gnt), .k_rvalid(k_rvalid), .k_rdata(k_rdata), .k_err(k_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory stand-in: single port, registered read.
  logic [63:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Reference model state
  logic [63:0] shadow [0:1023];
  bit          m_last_k, m_prev_lock, m_pv, m_po;
  logic [63:0] m_pd, m_hh, m_kh;

  // Observed values of the last step, for the directed checks
  logic        o_hg, o_kg, o_hrv, o_krv, o_kerr, o_mwe;
  logic [63:0] o_hrd, o_krd;
  bit          e_hg, e_kg, e_gw;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_last_k = 1; m_prev_lock = 0; m_pv = 0; m_po = 0; m_pd = '0; m_hh = '0; m_kh = '0;
  endtask

  // One clock cycle: drive at the falling edge, check 1 time unit later, update model at the rising edge.
  task automatic step(input bit r, input bit hl,
                      input bit hr, input bit hw, input logic [9:0] ha, input logic [63:0] hd,
                      input bit kr, input bit kw, input logic [9:0] ka, input logic [63:0] kd);
    bit lock_eff, oob, any, e_hrv, e_krv;
    logic [9:0]  ga;
    logic [63:0] gd;
    rst = r; host_lock = hl;
    h_req = hr; h_we = hw; h_addr = ha; h_wdata = hd;
    k_req = kr; k_we = kw; k_addr = ka; k_wdata = kd;
    #1;
    lock_eff = hl || m_prev_lock;
    e_hg = 0; e_kg = 0;
    if (!r) begin
      if (lock_eff)      e_hg = hr;
      else if (hr && kr) begin e_hg = m_last_k; e_kg = !m_last_k; end
      else               begin e_hg = hr; e_kg = kr; end
    end
    any  = e_hg || e_kg;
    ga   = e_kg ? ka : ha;
    gd   = e_kg ? kd : hd;
    e_gw = e_kg ? kw : hw;
    oob  = any && (int'(ga) >= 1000);
    e_hrv = !r && m_pv && !m_po;
    e_krv = !r && m_pv &&  m_po;
    o_hg = h_gnt; o_kg = k_gnt; o_hrv = h_rvalid; o_krv = k_rvalid;
    o_hrd = h_rdata; o_krd = k_rdata; o_kerr = k_err; o_mwe = mem_we;
    chk("h_gnt", h_gnt, e_hg);
    chk("k_gnt", k_gnt, e_kg);
    chk("h_err", h_err, e_hg && oob);
    chk("k_err", k_err, e_kg && oob);
    chk("mem_we", mem_we, any && e_gw && !oob);
    chk("h_rvalid", h_rvalid, e_hrv);
    chk("k_rvalid", k_rvalid, e_krv);
    if (!r) begin
      chk("h_rdata", h_rdata, e_hrv ? m_pd : m_hh);
      chk("k_rdata", k_rdata, e_krv ? m_pd : m_kh);
    end
    if (any && !oob) chk("mem_addr", mem_addr, ga);
    if (any && e_gw && !oob) chk("mem_wdata", mem_wdata, gd);
    $display("cyc t=%0t rst=%0b lock=%0b h=%0b/%0b k=%0b/%0b addr=%0d hrv=%0b krv=%0b",
             $time, r, hl, hr, h_gnt, kr, k_gnt, ga, h_rvalid, k_rvalid);
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (e_hrv) m_hh = m_pd;
      if (e_krv) m_kh = m_pd;
      m_pv = any && !e_gw;
      m_po = e_kg;
      m_pd = oob ? 64'd0 : shadow[ga];
      if (any && e_gw && !oob) shadow[ga] = gd;
      if (any && !lock_eff) m_last_k = e_kg;
      m_prev_lock = hl;
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit hl);
    step(0, hl, 0, 0, 10'd0, 64'd0, 0, 0, 10'd0, 64'd0);
  endtask

  bit          hr, hw, kr, kw, hl;
  logic [9:0]  ha, ka;
  logic [63:0] hd, kd;

  function automatic logic [9:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 10'($urandom_range(995, 1023));
    return 10'($urandom_range(0, 15));
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) begin mem[i] = '0; shadow[i] = '0; end
    model_reset();
    @(negedge clk);

    // Reset state
    step(1, 0, 0, 0, 10'd0, 64'd0, 0, 0, 10'd0, 64'd0);
    chk("reset_h_rdata", h_rdata, 64'd0);
    chk("reset_k_rdata", k_rdata, 64'd0);

    // Host only: write 5 = 42, read 5
    step(0, 0, 1, 1, 10'd5, 64'd42, 0, 0, 10'd0, 64'd0);
    chk("host_wr_gnt", o_hg, 1'b1);
    step(0, 0, 1, 0, 10'd5, 64'd0, 0, 0, 10'd0, 64'd0);
    chk("host_rd_gnt", o_hg, 1'b1);
    idle(0);
    chk("host_rvalid", o_hrv, 1'b1);
    chk("host_rdata", o_hrd, 64'd42);
    chk("host_k_rvalid", o_krv, 1'b0);

    // Contention from a fresh reset: H,K,H,K
    step(1, 0, 0, 0, 10'd0, 64'd0, 0, 0, 10'd0, 64'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 10'd1, 64'd0, 1, 0, 10'd5, 64'd0);
      chk("contend_h", o_hg, (i % 2 == 0) ? 1'b1 : 1'b0);
    end
    idle(0);
    chk("contend_last_k_rvalid", o_krv, 1'b1);
    chk("contend_last_k_rdata", o_krd, 64'd42);

    // Lock: kernel stalled throughout, first kernel grant the cycle after release
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 10'd0, 64'd0, 1, 0, 10'd2, 64'd0);
      chk("lock_k_gnt", o_kg, 1'b0);
    end
    step(0, 0, 0, 0, 10'd0, 64'd0, 1, 0, 10'd2, 64'd0);
    chk("lock_release_k_gnt0", o_kg, 1'b0);
    step(0, 0, 0, 0, 10'd0, 64'd0, 1, 0, 10'd2, 64'd0);
    chk("lock_release_k_gnt1", o_kg, 1'b1);

    // Out of range write then read
    step(0, 0, 0, 0, 10'd0, 64'd0, 1, 1, 10'd1000, 64'd7);
    chk("oob_wr_gnt", o_kg, 1'b1);
    chk("oob_wr_err", o_kerr, 1'b1);
    chk("oob_wr_mem_we", o_mwe, 1'b0);
    step(0, 0, 0, 0, 10'd0, 64'd0, 1, 0, 10'd1000, 64'd0);
    idle(0);
    chk("oob_rd_rvalid", o_krv, 1'b1);
    chk("oob_rd_rdata", o_krd, 64'd0);

    // Kernel read, host_lock raised the next cycle
    step(0, 0, 0, 0, 10'd0, 64'd0, 1, 0, 10'd5, 64'd0);
    idle(1);
    chk("lockafter_k_rvalid", o_krv, 1'b1);
    chk("lockafter_k_rdata", o_krd, 64'd42);
    idle(0);

    // Reset right after a read grant
    step(0, 0, 1, 0, 10'd5, 64'd0, 0, 0, 10'd0, 64'd0);
    step(1, 0, 0, 0, 10'd0, 64'd0, 0, 0, 10'd0, 64'd0);
    idle(0);
    chk("post_reset_h_rvalid", o_hrv, 1'b0);
    chk("post_reset_h_gnt", o_hg, 1'b0);

    // Random traffic; payload held stable until grant, occasional drop
    hr = 0; kr = 0; hl = 0; hw = 0; kw = 0; ha = 0; ka = 0; hd = 0; kd = 0;
    for (int c = 0; c < 3000; c++) begin
      bit r;
      if (!hr || $urandom_range(0, 9) == 0) begin
        hr = ($urandom_range(0, 3) != 0); hw = $urandom_range(0, 1);
        ha = rand_addr(); hd = {$urandom, $urandom};
      end
      if (!kr || $urandom_range(0, 9) == 0) begin
        kr = ($urandom_range(0, 3) != 0); kw = $urandom_range(0, 1);
        ka = rand_addr(); kd = {$urandom, $urandom};
      end
      if ($urandom_range(0, 7) == 0) hl = !hl;
      r = ($urandom_range(0, 199) == 0);
      step(r, hl, hr, hw, ha, hd, kr, kw, ka, kd);
      if (e_hg) hr = 0;
      if (e_kg) kr = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
